// File: rtl/blink_rate_controller_pkg.sv
// Shared types and defaults for the blink rate controller: FSM state encoding,
// default geometry, and the level clamp used when a request is granted.
package blink_rate_controller_pkg;

  localparam int DEF_N_REQ      = 2;
  localparam int DEF_LEVEL_W    = 3;
  localparam int DEF_MAX_LEVEL  = 7;
  localparam int DEF_SETTLE_CYC = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  // Compared as int so the clamp stays meaningful whatever LEVEL_W is.
  function automatic int clamp_level(input int lvl, input int max_lvl);
    return (lvl > max_lvl) ? max_lvl : lvl;
  endfunction

endpackage

// File: rtl/blink_rate_controller_if.sv
// Request/ack and shifter/timer control bundle between the requesters
// (master) and the blink rate controller (slave).
interface blink_rate_controller_if #(
  parameter int N_REQ   = 2,
  parameter int LEVEL_W = 3
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ*LEVEL_W-1:0] req_level;
  logic                     run_en;
  logic [N_REQ-1:0]         ack;
  logic                     shift_left;
  logic                     shift_right;
  logic                     count_en;
  logic [LEVEL_W-1:0]       cur_level;
  logic                     busy;

  modport master (
    output req, req_level, run_en,
    input  ack, shift_left, shift_right, count_en, cur_level, busy
  );

  modport slave (
    input  req, req_level, run_en,
    output ack, shift_left, shift_right, count_en, cur_level, busy
  );
endinterface

// File: rtl/blink_rate_controller_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr wins. The pointer register itself lives in the controller.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  always_comb begin : arb
    int j;
    // NOTE: every output gets a default before the loop so no path can infer a latch.
    j     = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/blink_rate_controller.sv
// Sequences the blinker's shifter/timer pair: grants one rate-change request at
// a time, steps the shifter one level per cycle, settles, then acks.
module blink_rate_controller
  import blink_rate_controller_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int RESET_LEVEL = 0,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC
) (
  input logic                 clk,
  input logic                 rst,
  blink_rate_controller_if.slave bus
);

  localparam int PTR_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int SETTLE_LOAD = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   gid_q, gid_d;
  logic [LEVEL_W-1:0] tgt_q, tgt_d;
  logic [LEVEL_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               sl_q, sl_d;
  logic               sr_q, sr_d;
  logic               busy_q;

  logic [N_REQ-1:0]   gnt_onehot;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic [LEVEL_W-1:0] sel_level;
  logic [LEVEL_W-1:0] req_tgt;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (bus.req),
    .ptr   (rr_ptr_q),
    .grant (gnt_onehot),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  // One-hot AND-OR select of the winner's requested level.
  always_comb begin
    sel_level = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_onehot[i]) sel_level |= bus.req_level[i*LEVEL_W +: LEVEL_W];
    end
  end

  assign req_tgt = LEVEL_W'(clamp_level(int'(sel_level), MAX_LEVEL));

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gid_d    = gid_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          gid_d    = gnt_idx;
          tgt_d    = req_tgt;
          rr_ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
          state_d  = (req_tgt == cur_q) ? ST_ACK : ST_STEP;
        end
      end
      ST_STEP: begin
        // cur_q already shows the level reached by this cycle's shift pulse.
        if (cur_q == tgt_q) begin
          state_d = (SETTLE_CYC == 0) ? ST_ACK : ST_SETTLE;
          cnt_d   = CNT_W'(SETTLE_LOAD);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_ACK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_ACK: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so pulses line up with it.
    sl_d  = (state_d == ST_STEP) && (tgt_d > cur_q);
    sr_d  = (state_d == ST_STEP) && (tgt_d < cur_q);
    cur_d = sl_d ? cur_q + LEVEL_W'(1) :
            sr_d ? cur_q - LEVEL_W'(1) : cur_q;
    for (int i = 0; i < N_REQ; i++) begin
      ack_d[i] = (state_d == ST_ACK) && (int'(gid_d) == i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      tgt_q    <= LEVEL_W'(RESET_LEVEL);
      cur_q    <= LEVEL_W'(RESET_LEVEL);
      cnt_q    <= '0;
      ack_q    <= '0;
      sl_q     <= 1'b0;
      sr_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      tgt_q    <= tgt_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      sl_q     <= sl_d;
      sr_q     <= sr_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign bus.ack         = ack_q;
  assign bus.shift_left  = sl_q;
  assign bus.shift_right = sr_q;
  assign bus.cur_level   = cur_q;
  assign bus.busy        = busy_q;
  // The timer only runs while the shifter is stable; rst gates it during reset.
  assign bus.count_en    = rst & bus.run_en & ((state_q == ST_IDLE) || (state_q == ST_ACK));

endmodule

// File: tb/tb_blink_rate_controller.sv
// Directed bench for blink_rate_controller: a schedule-based reference model
// checked every cycle, plus literal latency/count expectations per scenario.
module tb_blink_rate_controller;

  localparam int N_REQ      = 2;
  localparam int LEVEL_W    = 4;
  localparam int MAX_LEVEL  = 7;
  localparam int SETTLE_CYC = 2;

  typedef struct {
    logic               sl;
    logic               sr;
    logic [N_REQ-1:0]   ack;
    logic [LEVEL_W-1:0] cur;
    logic               busy;
    logic               cen;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blink_rate_controller_if #(.N_REQ(N_REQ), .LEVEL_W(LEVEL_W)) bus ();

  blink_rate_controller #(
    .N_REQ       (N_REQ),
    .LEVEL_W     (LEVEL_W),
    .MAX_LEVEL   (MAX_LEVEL),
    .RESET_LEVEL (0),
    .SETTLE_CYC  (SETTLE_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  int n_sl, n_sr, n_cen_low, n_ack, last_ack_cyc, req_cyc;
  logic [N_REQ-1:0] last_ack;
  int ack_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t idle_exp(input int c);
    exp_t e;
    e.sl = 1'b0; e.sr = 1'b0; e.ack = '0;
    e.cur = LEVEL_W'(c); e.busy = 1'b0; e.cen = 1'b1;
    return e;
  endfunction

  // Reference model: on a grant, lay out the whole operation as a list of
  // per-cycle expected outputs (d shifts, settle cycles, one ack cycle).
  exp_t cur_exp;
  exp_t sched[$];
  int m_cur = 0;
  int m_ptr = 0;

  always @(posedge clk or negedge rst) begin : model
    int g, tgt, d;
    exp_t e;
    if (!rst) begin
      sched.delete();
      m_cur = 0;
      m_ptr = 0;
      cur_exp = idle_exp(0);
    end else if (sched.size() > 0) begin
      cur_exp = sched.pop_front();
    end else if (cur_exp.busy) begin
      cur_exp = idle_exp(m_cur);
    end else begin
      g = -1;
      for (int i = 0; i < N_REQ; i++) begin
        if (g < 0 && bus.req[(m_ptr + i) % N_REQ]) g = (m_ptr + i) % N_REQ;
      end
      if (g < 0) begin
        cur_exp = idle_exp(m_cur);
      end else begin
        tgt = int'(bus.req_level[g*LEVEL_W +: LEVEL_W]);
        if (tgt > MAX_LEVEL) tgt = MAX_LEVEL;
        d = (tgt > m_cur) ? tgt - m_cur : m_cur - tgt;
        for (int k = 1; k <= d; k++) begin
          e = idle_exp((tgt > m_cur) ? m_cur + k : m_cur - k);
          e.sl = (tgt > m_cur); e.sr = (tgt < m_cur); e.busy = 1'b1; e.cen = 1'b0;
          sched.push_back(e);
        end
        if (d > 0) begin
          for (int s = 0; s < SETTLE_CYC; s++) begin
            e = idle_exp(tgt); e.busy = 1'b1; e.cen = 1'b0;
            sched.push_back(e);
          end
        end
        e = idle_exp(tgt); e.busy = 1'b1; e.ack[g] = 1'b1;
        sched.push_back(e);
        m_cur = tgt;
        m_ptr = (g + 1) % N_REQ;
        cur_exp = sched.pop_front();
      end
    end
  end

  always @(posedge clk) cyc++;

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("shift_left",  bus.shift_left,  cur_exp.sl);
      check("shift_right", bus.shift_right, cur_exp.sr);
      check("ack",         bus.ack,         cur_exp.ack);
      check("cur_level",   bus.cur_level,   cur_exp.cur);
      check("busy",        bus.busy,        cur_exp.busy);
      check("count_en",    bus.count_en,    rst & cur_exp.cen & bus.run_en);
      check("one_shift",   bus.shift_left & bus.shift_right, 0);
    end
  end

  always @(negedge clk) begin
    if (bus.shift_left)  n_sl++;
    if (bus.shift_right) n_sr++;
    if (!bus.count_en)   n_cen_low++;
    if (|bus.ack) begin
      n_ack++;
      last_ack_cyc = cyc;
      last_ack     = bus.ack;
      for (int i = 0; i < N_REQ; i++) if (bus.ack[i]) ack_log.push_back(i);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_req(input int idx, input int lvl);
    step();
    bus.req_level[idx*LEVEL_W +: LEVEL_W] = LEVEL_W'(lvl);
    bus.req[idx] = 1'b1;
    req_cyc   = cyc;
    n_sl      = 0;
    n_sr      = 0;
    n_cen_low = 0;
  endtask

  task automatic wait_acks(input int n, input int budget);
    int start;
    start = n_ack;
    for (int k = 0; k < budget && n_ack < start + n; k++) begin
      @(negedge clk);
      #1;
    end
    check("ack_arrived", n_ack - start, n);
  endtask

  task automatic release_req(input int idx);
    step();
    bus.req[idx] = 1'b0;
  endtask

  initial begin
    int base;
    cur_exp = idle_exp(0);
    n_ack = 0;
    rst = 1'b0;
    bus.req = '0;
    bus.req_level = '0;
    bus.run_en = 1'b1;
    step();
    chk_on = 1'b1;
    step();
    check("rst_cur",   bus.cur_level, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_cen",   bus.count_en, 0);
    check("rst_ack",   bus.ack, 0);
    rst = 1'b1;
    step();
    check("idle_cen", bus.count_en, 1);

    // Single up 0 -> 3.
    start_req(0, 3);
    wait_acks(1, 30);
    check("up_latency", last_ack_cyc - req_cyc, 6);
    check("up_shifts",  n_sl, 3);
    check("up_cen_low", n_cen_low, 5);
    check("up_cur",     bus.cur_level, 3);
    check("up_ack_id",  last_ack, 2'b01);
    release_req(0);

    // Reset mid-STEP on the way 3 -> 6, once cur_level shows 4.
    start_req(0, 6);
    for (int k = 0; k < 10 && bus.cur_level != 4; k++) step();
    rst = 1'b0;
    base = n_ack;
    #1;
    check("midrst_cur",  bus.cur_level, 0);
    check("midrst_sl",   bus.shift_left, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_cen",  bus.count_en, 0);
    step();
    step();
    bus.req = '0;
    rst = 1'b1;
    step();
    step();
    check("postrst_cen",   bus.count_en, 1);
    check("postrst_noack", n_ack - base, 0);
    check("postrst_cur",   bus.cur_level, 0);

    // No-op: bring to 4, then request 4 again.
    start_req(0, 4);
    wait_acks(1, 30);
    release_req(0);
    start_req(0, 4);
    wait_acks(1, 10);
    check("noop_latency", last_ack_cyc - req_cyc, 1);
    check("noop_shifts",  n_sl + n_sr, 0);
    check("noop_cen_low", n_cen_low, 0);
    release_req(0);

    // Up with clamp, then down: 4 -> 5, 5 -> 9 (clamped to 7), 7 -> 2.
    start_req(1, 5);
    wait_acks(1, 30);
    release_req(1);
    start_req(1, 9);
    wait_acks(1, 30);
    check("clamp_latency", last_ack_cyc - req_cyc, 5);
    check("clamp_shifts",  n_sl, 2);
    check("clamp_cur",     bus.cur_level, 7);
    check("clamp_ack_id",  last_ack, 2'b10);
    release_req(1);
    start_req(1, 2);
    wait_acks(1, 30);
    check("down_shifts",  n_sr, 5);
    check("down_up",      n_sl, 0);
    check("down_cur",     bus.cur_level, 2);
    check("down_latency", last_ack_cyc - req_cyc, 8);
    release_req(1);

    // Fairness: both held, differing levels.
    step();
    ack_log.delete();
    bus.req_level = {4'd1, 4'd6};
    bus.req = 2'b11;
    wait_acks(4, 100);
    bus.req = 2'b00;
    check("fair_count", ack_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (ack_log.size() > i) check("fair_order", ack_log[i], i % 2);
    end
    check("fair_cur", bus.cur_level, 1);
    step();

    // Robustness: drop req and change level mid-STEP; toggle run_en while busy.
    start_req(0, 7);
    base = n_ack;
    step();
    step();
    bus.req[0] = 1'b0;
    bus.req_level[0 +: LEVEL_W] = 4'd0;
    bus.run_en = 1'b0;
    step();
    bus.run_en = 1'b1;
    step();
    bus.run_en = 1'b0;
    step();
    bus.run_en = 1'b1;
    wait_acks(1, 30);
    check("robust_cur",    bus.cur_level, 7);
    check("robust_shifts", n_sl, 6);
    check("robust_ack_id", last_ack, 2'b01);
    repeat (6) step();
    check("robust_one_ack", n_ack - base, 1);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
